// File: rtl/evm_ballot_ctrl.sv
// Per-voter ballot sequencer: arms one ballot, debounces and validates the press, strobes one party counter.
// Optional feature: define EVM_CTRL_INVALID_RETRY_EN to give the voter one retry after an invalid press.
module evm_ballot_ctrl #(
  parameter int N_PARTY     = 3,
  parameter int DEB_CYCLES  = 4,
  parameter int TIMEOUT_CYC = 1000,
  parameter int TOT_W       = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               session_open,
  input  logic               ballot_req,
  input  logic [N_PARTY-1:0] voter_switch,
  output logic [N_PARTY-1:0] vote_inc,
  output logic               ballot_armed,
  output logic               invalid,
  output logic               timeout,
  output logic               ballot_done,
  output logic [TOT_W-1:0]   total_votes,
  output logic [TOT_W-1:0]   invalid_cnt
);

  localparam int DEB_W = $clog2(DEB_CYCLES + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYC);

  typedef enum logic [2:0] {
    S_CLOSED, S_IDLE, S_ARMED, S_DEBOUNCE, S_COMMIT, S_RELEASE
  } state_t;

  state_t             state, state_nxt;
  logic [DEB_W-1:0]   deb_cnt, deb_nxt;
  logic [TMO_W-1:0]   tmo_cnt, tmo_nxt;
  logic [N_PARTY-1:0] cap, cap_nxt;
  logic [TOT_W-1:0]   total_nxt, inv_nxt;
  logic               cap_onehot;
`ifdef EVM_CTRL_INVALID_RETRY_EN
  logic               retry_used, retry_used_nxt;
  logic               last_inv, last_inv_nxt;
`endif

  assign cap_onehot = (cap != '0) && ((cap & (cap - 1'b1)) == '0);

  // NOTE: every variable assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt   = state;
    deb_nxt     = deb_cnt;
    tmo_nxt     = tmo_cnt;
    cap_nxt     = cap;
    total_nxt   = total_votes;
    inv_nxt     = invalid_cnt;
    vote_inc    = '0;
    invalid     = 1'b0;
    timeout     = 1'b0;
    ballot_done = 1'b0;
`ifdef EVM_CTRL_INVALID_RETRY_EN
    retry_used_nxt = retry_used;
    last_inv_nxt   = last_inv;
`endif
    unique case (state)
      S_CLOSED: begin
        if (session_open) begin
          state_nxt = S_IDLE;
          total_nxt = '0;
          inv_nxt   = '0;
        end
      end
      S_IDLE: begin
        if (!session_open) begin
          state_nxt = S_CLOSED;
        end else if (ballot_req) begin
          state_nxt = S_ARMED;
          tmo_nxt   = '0;
          deb_nxt   = '0;
`ifdef EVM_CTRL_INVALID_RETRY_EN
          retry_used_nxt = 1'b0;
          last_inv_nxt   = 1'b0;
`endif
        end
      end
      S_ARMED: begin
        // Expiry wins over a press arriving in the very last armed cycle.
        if (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) begin
          timeout   = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          tmo_nxt = tmo_cnt + 1'b1;
          if (voter_switch != '0) begin
            cap_nxt   = voter_switch;
            deb_nxt   = DEB_W'(1);
            state_nxt = S_DEBOUNCE;
          end
        end
      end
      S_DEBOUNCE: begin
        if (deb_cnt == DEB_W'(DEB_CYCLES)) begin
          deb_nxt = '0;
          if (cap_onehot) begin
            state_nxt = S_COMMIT;
          end else begin
            invalid   = 1'b1;
            state_nxt = S_RELEASE;
            if (invalid_cnt != '1) inv_nxt = invalid_cnt + 1'b1;
`ifdef EVM_CTRL_INVALID_RETRY_EN
            last_inv_nxt = 1'b1;
`endif
          end
        end else if (voter_switch == '0) begin
          state_nxt = S_ARMED;
        end else if (voter_switch == cap) begin
          deb_nxt = deb_cnt + 1'b1;
        end else begin
          cap_nxt = voter_switch;
          deb_nxt = DEB_W'(1);
        end
      end
      S_COMMIT: begin
        vote_inc  = cap;
        deb_nxt   = '0;
        state_nxt = S_RELEASE;
        if (total_votes != '1) total_nxt = total_votes + 1'b1;
      end
      S_RELEASE: begin
        if (deb_cnt == DEB_W'(DEB_CYCLES)) begin
          deb_nxt = '0;
`ifdef EVM_CTRL_INVALID_RETRY_EN
          if (last_inv && !retry_used) begin
            state_nxt      = S_ARMED;
            tmo_nxt        = '0;
            retry_used_nxt = 1'b1;
            last_inv_nxt   = 1'b0;
          end else begin
            ballot_done = 1'b1;
            state_nxt   = session_open ? S_IDLE : S_CLOSED;
          end
`else
          ballot_done = 1'b1;
          state_nxt   = session_open ? S_IDLE : S_CLOSED;
`endif
        end else if (voter_switch == '0) begin
          deb_nxt = deb_cnt + 1'b1;
        end else begin
          deb_nxt = '0;
        end
      end
      default: state_nxt = S_CLOSED;
    endcase
  end

  assign ballot_armed = (state == S_ARMED) || (state == S_DEBOUNCE);

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_CLOSED;
      deb_cnt     <= '0;
      tmo_cnt     <= '0;
      cap         <= '0;
      total_votes <= '0;
      invalid_cnt <= '0;
`ifdef EVM_CTRL_INVALID_RETRY_EN
      retry_used  <= 1'b0;
      last_inv    <= 1'b0;
`endif
    end else begin
      state       <= state_nxt;
      deb_cnt     <= deb_nxt;
      tmo_cnt     <= tmo_nxt;
      cap         <= cap_nxt;
      total_votes <= total_nxt;
      invalid_cnt <= inv_nxt;
`ifdef EVM_CTRL_INVALID_RETRY_EN
      retry_used  <= retry_used_nxt;
      last_inv    <= last_inv_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_evm_ballot_ctrl.sv
// Directed bench for evm_ballot_ctrl (default parameters); pulse monitor plus hand-computed expectations.
module tb_evm_ballot_ctrl;

  localparam int DEB = 4;
  localparam int TMO = 1000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       session_open = 1'b0;
  logic       ballot_req = 1'b0;
  logic [2:0] voter_switch = 3'b000;
  logic [2:0] vote_inc;
  logic       ballot_armed, invalid, timeout, ballot_done;
  logic [8:0] total_votes, invalid_cnt;

  evm_ballot_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .session_open (session_open),
    .ballot_req   (ballot_req),
    .voter_switch (voter_switch),
    .vote_inc     (vote_inc),
    .ballot_armed (ballot_armed),
    .invalid      (invalid),
    .timeout      (timeout),
    .ballot_done  (ballot_done),
    .total_votes  (total_votes),
    .invalid_cnt  (invalid_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int pcnt = 0;
  int n_vote = 0, n_inv = 0, n_tmo = 0, n_done = 0;
  int vote_cyc = -1, done_cyc = -1, tmo_cyc = -1;
  logic [2:0] last_vote = 3'b000;

  always @(posedge clk) pcnt++;

  // Pulse monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (vote_inc != 3'b000) begin
      n_vote++;
      last_vote = vote_inc;
      vote_cyc  = pcnt;
    end
    if (invalid) n_inv++;
    if (timeout) begin
      n_tmo++;
      tmo_cyc = pcnt;
    end
    if (ballot_done) begin
      n_done++;
      done_cyc = pcnt;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_vote(input logic [2:0] p);
    ballot_req = 1'b1;
    step(1);
    ballot_req = 1'b0;
    voter_switch = p;
    step(DEB + 3);
    voter_switch = 3'b000;
    step(DEB + 2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k, m, v0, d0, i0, t0;
    logic [8:0] exp_total;

    // Reset state
    step(3);
    chk("rst_vote_inc", vote_inc, 0);
    chk("rst_armed", ballot_armed, 0);
    chk("rst_total", total_votes, 0);
    chk("rst_invalid_cnt", invalid_cnt, 0);
    chk("rst_pulses", {invalid, timeout, ballot_done}, 0);
    rst = 1'b0;
    session_open = 1'b1;
    step(1);
    chk("idle_armed", ballot_armed, 0);
    chk("idle_total", total_votes, 0);
    exp_total = 0;

    // Valid vote 010, latency and release
    ballot_req = 1'b1;
    step(1);
    ballot_req = 1'b0;
    chk("armed_led", ballot_armed, 1);
    v0 = n_vote; d0 = n_done;
    voter_switch = 3'b010;
    k = pcnt;
    step(10);
    chk("v1_count", n_vote - v0, 1);
    chk("v1_value", last_vote, 3'b010);
    chk("v1_latency", vote_cyc - k, DEB + 1);
    exp_total++;
    chk("v1_total", total_votes, exp_total);
    chk("v1_no_done_held", n_done - d0, 0);
    voter_switch = 3'b000;
    m = pcnt;
    step(6);
    chk("v1_done", n_done - d0, 1);
    chk("v1_done_cyc", done_cyc - m, DEB);
    chk("v1_idle", ballot_armed, 0);

    // Invalid press 011
    v0 = n_vote; d0 = n_done; i0 = n_inv;
    ballot_req = 1'b1;
    step(1);
    ballot_req = 1'b0;
    voter_switch = 3'b011;
    step(DEB + 3);
    chk("inv_pulse", n_inv - i0, 1);
    chk("inv_cnt", invalid_cnt, 1);
    chk("inv_no_vote", n_vote - v0, 0);
    voter_switch = 3'b000;
    step(6);
`ifdef EVM_CTRL_INVALID_RETRY_EN
    chk("retry_no_done", n_done - d0, 0);
    chk("retry_armed", ballot_armed, 1);
    voter_switch = 3'b001;
    step(DEB + 3);
    voter_switch = 3'b000;
    step(DEB + 2);
    chk("retry_vote_count", n_vote - v0, 1);
    chk("retry_vote_value", last_vote, 3'b001);
    exp_total++;
    chk("retry_total", total_votes, exp_total);
    chk("retry_done", n_done - d0, 1);
`else
    chk("inv_done", n_done - d0, 1);
    chk("inv_idle", ballot_armed, 0);
    chk("inv_total", total_votes, exp_total);
`endif

    // Bounce, then held switch through extra requests
    v0 = n_vote; d0 = n_done;
    ballot_req = 1'b1;
    step(1);
    ballot_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      voter_switch = (i % 2 == 0) ? 3'b001 : 3'b000;
      step(1);
    end
    voter_switch = 3'b001;
    step(DEB + 3);
    for (int i = 0; i < 3; i++) begin
      ballot_req = 1'b1;
      step(1);
      ballot_req = 1'b0;
      step(1);
    end
    voter_switch = 3'b000;
    step(6);
    chk("bounce_count", n_vote - v0, 1);
    chk("bounce_value", last_vote, 3'b001);
    exp_total++;
    chk("bounce_total", total_votes, exp_total);
    chk("bounce_done", n_done - d0, 1);
    chk("bounce_invalid_cnt", invalid_cnt, 1);

    // Timeout
    t0 = n_tmo; d0 = n_done;
    ballot_req = 1'b1;
    k = pcnt;
    step(1);
    ballot_req = 1'b0;
    step(TMO + 5);
    chk("tmo_pulse", n_tmo - t0, 1);
    chk("tmo_cyc", tmo_cyc - k, TMO);
    chk("tmo_no_done", n_done - d0, 0);
    chk("tmo_idle", ballot_armed, 0);
    chk("tmo_total", total_votes, exp_total);

    // Session drop during debounce is deferred
    v0 = n_vote; d0 = n_done;
    ballot_req = 1'b1;
    step(1);
    ballot_req = 1'b0;
    voter_switch = 3'b100;
    step(2);
    session_open = 1'b0;
    step(5);
    voter_switch = 3'b000;
    step(6);
    chk("drop_vote_count", n_vote - v0, 1);
    chk("drop_vote_value", last_vote, 3'b100);
    exp_total++;
    chk("drop_total", total_votes, exp_total);
    chk("drop_done", n_done - d0, 1);
    ballot_req = 1'b1;
    step(2);
    ballot_req = 1'b0;
    chk("closed_ignores_req", ballot_armed, 0);
    chk("closed_keeps_total", total_votes, exp_total);
    session_open = 1'b1;
    step(1);
    chk("reopen_total_clr", total_votes, 0);
    chk("reopen_inv_clr", invalid_cnt, 0);

    // Reset mid-ballot: no partial vote
    v0 = n_vote;
    ballot_req = 1'b1;
    step(1);
    ballot_req = 1'b0;
    voter_switch = 3'b010;
    step(2);
    rst = 1'b1;
    #1;
    chk("midrst_armed", ballot_armed, 0);
    chk("midrst_vote_inc", vote_inc, 0);
    step(6);
    rst = 1'b0;
    voter_switch = 3'b000;
    step(8);
    chk("midrst_no_vote", n_vote - v0, 0);
    chk("midrst_total", total_votes, 0);

    // Saturation of total_votes
    for (int i = 0; i < 513; i++) do_vote(3'b100);
    chk("sat_total", total_votes, 9'd511);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
